// File: rtl/xadac_pkg.sv
// rtl/xadac_pkg.sv - shared xadac types, vdot state enum and vdot helpers
package xadac_pkg;

  localparam int unsigned XLen         = 32;
  localparam int unsigned VecDataWidth = 128;
  localparam int unsigned VecElemWidth = 8;
  localparam int unsigned IdWidth      = 4;
  localparam int unsigned RegAddrWidth = 5;
  localparam int unsigned VdotMaxLen   = VecDataWidth / VecElemWidth;
  localparam int unsigned VdotLenWidth = $clog2(VdotMaxLen + 1);

  typedef logic [31:0]              InstrT;
  typedef logic [IdWidth-1:0]       IdT;
  typedef logic [RegAddrWidth-1:0]  RegAddrT;
  typedef logic [VecElemWidth-1:0]  VecElemT;
  typedef logic [XLen-1:0]          VecSumT;
  typedef logic [VecDataWidth-1:0]  VecDataT;

  typedef struct packed {
    IdT                         id;
    InstrT                      instr;
    logic [1:0][RegAddrWidth-1:0] rs_addr;
    logic [1:0][XLen-1:0]         rs_data;
    logic [2:0][RegAddrWidth-1:0] vs_addr;
    logic [2:0][VecDataWidth-1:0] vs_data;
  } ExeReqT;

  typedef struct packed {
    IdT      id;
    RegAddrT rd_addr;
    VecSumT  rd_data;
    logic    rd_write;
    RegAddrT vd_addr;
    VecDataT vd_data;
    logic    vd_write;
  } ExeRspT;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } VdotStateT;

  function automatic RegAddrT vdot_rd(InstrT instr);
    return instr[11:7];
  endfunction

  function automatic logic vdot_signed(InstrT instr);
    return instr[12];
  endfunction

  // Lengths above the register width of elements saturate to a full vector.
  function automatic logic [VdotLenWidth-1:0] vdot_len(logic [VdotLenWidth-1:0] raw);
    return (raw > VdotLenWidth'(VdotMaxLen)) ? VdotLenWidth'(VdotMaxLen) : raw;
  endfunction

endpackage

// File: rtl/xadac_vdot_if.sv
// rtl/xadac_vdot_if.sv - request/response handshake bundle between issue and vdot unit
interface xadac_vdot_if;
  import xadac_pkg::*;

  logic   req_valid;
  logic   req_ready;
  ExeReqT req;
  logic   rsp_valid;
  logic   rsp_ready;
  ExeRspT rsp;

  modport master (
    output req_valid, req, rsp_ready,
    input  req_ready, rsp_valid, rsp
  );

  modport slave (
    input  req_valid, req, rsp_ready,
    output req_ready, rsp_valid, rsp
  );
endinterface

// File: rtl/xadac_vdot_tree.sv
// rtl/xadac_vdot_tree.sv - combinational masked multiply/reduce of one group of element pairs
module xadac_vdot_tree
  import xadac_pkg::*;
#(
  parameter int unsigned Lanes = 4
) (
  input  VecElemT [Lanes-1:0] a_i,
  input  VecElemT [Lanes-1:0] b_i,
  input  logic    [Lanes-1:0] mask_i,
  input  logic                signed_i,
  output VecSumT              sum_o
);

  always_comb begin
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] prod;
    VecSumT      ext;
    sum_o = '0;
    ea    = '0;
    eb    = '0;
    prod  = '0;
    ext   = '0;
    for (int j = 0; j < Lanes; j++) begin
      // Extending to 16 bits first makes the low half of the product correct for both signednesses.
      ea   = signed_i ? {{8{a_i[j][7]}}, a_i[j]} : {8'b0, a_i[j]};
      eb   = signed_i ? {{8{b_i[j][7]}}, b_i[j]} : {8'b0, b_i[j]};
      prod = ea * eb;
      ext  = signed_i ? {{16{prod[15]}}, prod} : {16'b0, prod};
      if (mask_i[j]) begin
        sum_o = sum_o + ext;
      end
    end
  end

endmodule

// File: rtl/xadac_vdot.sv
// rtl/xadac_vdot.sv - multi-cycle vector dot-product unit, LanesPerCycle pairs per cycle
// Build option XADAC_VDOT_SAT_EN: saturate every accumulation step instead of wrapping.
module xadac_vdot
  import xadac_pkg::*;
#(
  parameter int unsigned LanesPerCycle = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  xadac_vdot_if.slave exe,
  output logic        busy_o
);

  localparam int unsigned LaneBits = LanesPerCycle * VecElemWidth;
  localparam int unsigned CntW     = VdotLenWidth + 1;

  function automatic VecSumT acc_add(VecSumT acc, VecSumT part, logic sgn);
    logic [XLen:0] sum;
    sum = sgn ? ({acc[XLen-1], acc} + {part[XLen-1], part})
              : ({1'b0, acc} + {1'b0, part});
`ifdef XADAC_VDOT_SAT_EN
    if (sgn && (sum[XLen] != sum[XLen-1])) begin
      return sum[XLen] ? {1'b1, {(XLen-1){1'b0}}} : {1'b0, {(XLen-1){1'b1}}};
    end
    if (!sgn && sum[XLen]) begin
      return '1;
    end
`endif
    return sum[XLen-1:0];
  endfunction

  VdotStateT                 state_q, state_d;
  logic [VdotLenWidth-1:0]   cnt_q, cnt_d;
  logic [VdotLenWidth-1:0]   len_q, len_d;
  VecSumT                    acc_q, acc_d;
  VecDataT                   a_q, a_d;
  VecDataT                   b_q, b_d;
  IdT                        id_q, id_d;
  RegAddrT                   rd_q, rd_d;
  logic                      signed_q, signed_d;

  VecElemT [LanesPerCycle-1:0] lane_a;
  VecElemT [LanesPerCycle-1:0] lane_b;
  logic    [LanesPerCycle-1:0] lane_mask;
  VecSumT                      partial;
  logic    [CntW-1:0]          cnt_step;

  // Operand registers shift down each RUN cycle, so the active group is always the low lanes.
  for (genvar j = 0; j < LanesPerCycle; j++) begin : g_lane
    assign lane_a[j]    = a_q[j*VecElemWidth +: VecElemWidth];
    assign lane_b[j]    = b_q[j*VecElemWidth +: VecElemWidth];
    assign lane_mask[j] = ({1'b0, cnt_q} + CntW'(j)) < {1'b0, len_q};
  end

  xadac_vdot_tree #(
    .Lanes(LanesPerCycle)
  ) u_tree (
    .a_i     (lane_a),
    .b_i     (lane_b),
    .mask_i  (lane_mask),
    .signed_i(signed_q),
    .sum_o   (partial)
  );

  assign cnt_step = {1'b0, cnt_q} + CntW'(LanesPerCycle);
  assign busy_o   = (state_q != IDLE);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    acc_d         = acc_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    rd_d          = rd_q;
    signed_d      = signed_q;
    exe.req_ready = 1'b0;
    exe.rsp_valid = 1'b0;
    exe.rsp       = '0;
    unique case (state_q)
      IDLE: begin
        exe.req_ready = 1'b1;
        if (exe.req_valid) begin
          a_d      = exe.req.vs_data[0];
          b_d      = exe.req.vs_data[1];
          acc_d    = exe.req.rs_data[0];
          len_d    = vdot_len(exe.req.rs_data[1][VdotLenWidth-1:0]);
          id_d     = exe.req.id;
          rd_d     = vdot_rd(exe.req.instr);
          signed_d = vdot_signed(exe.req.instr);
          cnt_d    = '0;
          state_d  = (len_d == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        acc_d = acc_add(acc_q, partial, signed_q);
        a_d   = a_q >> LaneBits;
        b_d   = b_q >> LaneBits;
        cnt_d = cnt_step[VdotLenWidth-1:0];
        if (cnt_step >= {1'b0, len_q}) begin
          state_d = DONE;
        end
      end
      DONE: begin
        exe.rsp_valid        = 1'b1;
        exe.rsp.id           = id_q;
        exe.rsp.rd_addr      = rd_q;
        exe.rsp.rd_data      = acc_q;
        exe.rsp.rd_write     = 1'b1;
        if (exe.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      rd_q     <= '0;
      signed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      rd_q     <= rd_d;
      signed_q <= signed_d;
    end
  end

  logic unused_req;
  assign unused_req = ^{exe.req.rs_addr, exe.req.vs_addr, exe.req.vs_data[2],
                        exe.req.rs_data[1][XLen-1:VdotLenWidth],
                        exe.req.instr[31:13], exe.req.instr[6:0]};

endmodule

// File: tb/tb_xadac_vdot.sv
// tb/tb_xadac_vdot.sv - directed vector bench for xadac_vdot with LanesPerCycle=4
module tb_xadac_vdot;
  import xadac_pkg::*;

  typedef struct {
    string       name;
    logic [127:0] a;
    logic [127:0] b;
    logic [31:0] acc;
    logic [31:0] len;
    logic        sgn;
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

`ifdef XADAC_VDOT_SAT_EN
  localparam logic [31:0] ExpSatA = 32'hFFFF_FFFF;
  localparam logic [31:0] ExpSatB = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] ExpSatA = 32'h0000_00F0;
  localparam logic [31:0] ExpSatB = 32'h8000_0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  int   checks = 0;
  int   errors = 0;

  xadac_vdot_if bus ();

  xadac_vdot #(
    .LanesPerCycle(4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .exe   (bus),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req            = '0;
    bus.req.id         = v.id;
    bus.req.instr      = {19'b0, v.sgn, v.rd, 7'h2B};
    bus.req.rs_addr    = {5'd31, 5'd17};
    bus.req.rs_data[0] = v.acc;
    bus.req.rs_data[1] = v.len;
    bus.req.vs_data[0] = v.a;
    bus.req.vs_data[1] = v.b;
    bus.req.vs_data[2] = {16{8'h5A}};
  endtask

  // Counts cycles after the accept edge until rsp_valid, bounded.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!bus.rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input string nm);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check({nm, "_valid_drops"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    drive_req(v);
    bus.req_valid = 1'b1;
    check({v.name, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
    check({v.name, "_rd_data"}, bus.rsp.rd_data, v.exp);
    check({v.name, "_id"}, 32'(bus.rsp.id), 32'(v.id));
    check({v.name, "_rd_addr"}, 32'(bus.rsp.rd_addr), 32'(v.rd));
    check({v.name, "_writes"}, {bus.rsp.rd_write, bus.rsp.vd_write, bus.rsp.vd_addr},
          {1'b1, 1'b0, 5'd0, 25'd0} >> 25);
    check({v.name, "_vd_data_zero"}, 32'(bus.rsp.vd_data == '0), 32'd1);
    handshake(v.name);
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    int lat;
    vec_t bp1;
    vec_t bp2;

    vecs[0]  = '{"basic",   {16{8'h01}}, {16{8'h02}}, 32'd10,        32'd16, 1'b0, 4'd3,  5'd7,  32'h0000_002A, 5};
    vecs[1]  = '{"signed",  {16{8'hFF}}, {16{8'h02}}, 32'd0,         32'd3,  1'b1, 4'd1,  5'd2,  32'hFFFF_FFFA, 2};
    vecs[2]  = '{"unsigned",{16{8'hFF}}, {16{8'h02}}, 32'd0,         32'd3,  1'b0, 4'd2,  5'd3,  32'h0000_05FA, 2};
    vecs[3]  = '{"len0",    {16{8'h01}}, {16{8'h01}}, 32'h1234,      32'd0,  1'b0, 4'd4,  5'd4,  32'h0000_1234, 1};
    vecs[4]  = '{"clamp31", {16{8'h01}}, {16{8'h01}}, 32'd100,       32'd31, 1'b0, 4'd5,  5'd5,  32'd116,       5};
    vecs[5]  = '{"sat_a",   128'h10,     128'h10,     32'hFFFF_FFF0, 32'd1,  1'b0, 4'd6,  5'd6,  ExpSatA,       2};
    vecs[6]  = '{"sat_b",   128'h01,     128'h01,     32'h7FFF_FFFF, 32'd1,  1'b1, 4'd7,  5'd8,  ExpSatB,       2};
    vecs[7]  = '{"mask5",   {16{8'h80}}, {16{8'h80}}, 32'd0,         32'd5,  1'b1, 4'd8,  5'd9,  32'h0001_4000, 3};
    vecs[8]  = '{"uff",     {16{8'hFF}}, {16{8'hFF}}, 32'd0,         32'd16, 1'b0, 4'd9,  5'd10, 32'h000F_E010, 5};
    vecs[9]  = '{"negacc",  {16{8'h7F}}, {16{8'h81}}, 32'hFFFF_FFFF, 32'd2,  1'b1, 4'd10, 5'd11, 32'hFFFF_81FD, 2};
    vecs[10] = '{"len4",    128'h04030201, {16{8'h01}}, 32'd0,       32'd4,  1'b0, 4'd11, 5'd12, 32'd10,        2};
    vecs[11] = '{"len17",   {16{8'h01}}, {16{8'h01}}, 32'd0,         32'd17, 1'b0, 4'd12, 5'd13, 32'd16,        5};

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req       = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_zero", 32'(bus.rsp == '0), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: response held with a second request already waiting.
    bp1 = '{"bp1", 128'h04030201, {16{8'h01}}, 32'd5,     32'd4, 1'b0, 4'd13, 5'd14, 32'd15,     2};
    bp2 = '{"bp2", {16{8'h01}},  {16{8'h01}}, 32'hBEEF,   32'd0, 1'b0, 4'd14, 5'd15, 32'hBEEF,   1};
    drive_req(bp1);
    bus.req_valid = 1'b1;
    tick();
    drive_req(bp2);
    wait_rsp(lat);
    check("bp_latency", 32'(lat), 32'd2);
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_hold_data", bus.rsp.rd_data, 32'd15);
      check("bp_hold_id", 32'(bus.rsp.id), 32'd13);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp_after_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_after_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    wait_rsp(lat);
    check("bp2_latency", 32'(lat), 32'd1);
    check("bp2_rd_data", bus.rsp.rd_data, 32'hBEEF);
    check("bp2_id", 32'(bus.rsp.id), 32'd14);
    handshake("bp2");

    // Reset during RUN must drop the instruction silently.
    drive_req(vecs[0]);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    check("rr_busy_run", 32'(busy), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rr_busy_after", 32'(busy), 32'd0);
    check("rr_valid_after", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) n++;
      tick();
    end
    check("rr_no_rsp", 32'(n), 32'd0);
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
